// File: rtl/sprite_attr_dbuf.sv
// Double-buffered sprite attribute table: CPU writes the back bank, the renderer reads the front bank,
// swaps are deferred to frame_start, and a clear engine zeroes the back bank one entry per cycle.
module sprite_attr_dbuf #(
  parameter int NUM_SPRITE = 32,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(NUM_SPRITE)-1:0] wa,
  input  logic [DATA_W-1:0]             d,
  input  logic [DATA_W/8-1:0]           be,
  input  logic                          write,
  input  logic [$clog2(NUM_SPRITE)-1:0] ra,
  output logic [DATA_W-1:0]             q,
  input  logic                          swap_req,
  input  logic                          frame_start,
  input  logic                          clear_req,
  output logic                          swap_pending,
  output logic                          busy,
  output logic                          front_bank
);

  localparam int AW = $clog2(NUM_SPRITE);
  localparam int BW = DATA_W / 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [AW-1:0]     counter_r, counter_s;
  logic              busy_r;
  logic              front_bank_r;
  logic              swap_pending_r;
  logic [DATA_W-1:0] q_r;
  logic [DATA_W-1:0] mem_r [0:2*NUM_SPRITE-1];

  logic              pend_nx_s;
  logic              do_swap_s;
  logic [AW:0]       rd_idx_s;
  logic [AW:0]       wr_idx_s;
  logic [AW:0]       clr_idx_s;

  // The back bank is always the one not being read; the swap waits while clear owns it.
  assign pend_nx_s = swap_pending_r | swap_req;
  assign do_swap_s = frame_start & pend_nx_s & ~busy_r;
  assign rd_idx_s  = {front_bank_r, ra};
  assign wr_idx_s  = {~front_bank_r, wa};
  assign clr_idx_s = {~front_bank_r, counter_r};

  // Clear engine next-state and sweep counter.
  always_comb begin
    state_s   = state_r;
    counter_s = counter_r;
    case (state_r)
      IDLE: begin
        if (clear_req) begin
          state_s   = CLEAR;
          counter_s = '0;
        end else begin
          state_s   = IDLE;
        end
      end
      CLEAR: begin
        counter_s = counter_r + AW'(1);
        if (counter_r == AW'(NUM_SPRITE - 1)) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
        end
      end
      default: begin
        state_s   = IDLE;
        counter_s = '0;
      end
    endcase
  end

  // Control state, bank select and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      counter_r      <= '0;
      busy_r         <= 1'b0;
      front_bank_r   <= 1'b0;
      swap_pending_r <= 1'b0;
      q_r            <= '0;
    end else begin
      state_r   <= state_s;
      counter_r <= counter_s;
      busy_r    <= (state_s == CLEAR);
      q_r       <= mem_r[rd_idx_s];
      if (do_swap_s) begin
        front_bank_r   <= ~front_bank_r;
        swap_pending_r <= 1'b0;
      end else begin
        swap_pending_r <= pend_nx_s;
      end
    end
  end

  // Back-bank storage; contents survive reset, and CPU writes are dropped while clearing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy_r) begin
        mem_r[clr_idx_s] <= '0;
      end else if (write) begin
        for (int i = 0; i < BW; i++) begin
          if (be[i]) begin
            mem_r[wr_idx_s][8*i +: 8] <= d[8*i +: 8];
          end
        end
      end
    end
  end

  assign q            = q_r;
  assign swap_pending = swap_pending_r;
  assign busy         = busy_r;
  assign front_bank   = front_bank_r;

endmodule

// File: tb/tb_sprite_attr_dbuf.sv
// Directed bench for sprite_attr_dbuf: a cycle-level bank model is compared every cycle,
// and literal expectations pin the model at the key points of each scenario.
module tb_sprite_attr_dbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  wa, ra;
  logic [31:0] d, q;
  logic [3:0]  be;
  logic        write, swap_req, frame_start, clear_req;
  logic        swap_pending, busy, front_bank;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  sprite_attr_dbuf #(.NUM_SPRITE(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .wa(wa), .d(d), .be(be), .write(write), .ra(ra), .q(q),
    .swap_req(swap_req), .frame_start(frame_start), .clear_req(clear_req),
    .swap_pending(swap_pending), .busy(busy), .front_bank(front_bank)
  );

  always #5 clk = ~clk;

  // Behavioural model: two banks as a 2-D array, busy as cycles of clearing left.
  logic [31:0] m_mem [2][32];
  logic        m_front = 1'b0;
  logic        m_pend  = 1'b0;
  logic [31:0] m_q     = 32'd0;
  int          m_left  = 0;
  int          m_clr   = 0;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32; a++)
        m_mem[b][a] = 32'd0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_q     <= 32'd0;
      m_front <= 1'b0;
      m_pend  <= 1'b0;
      m_left  <= 0;
      m_clr   <= 0;
    end else begin
      m_q <= m_mem[m_front][ra];
      if (frame_start && (m_pend || swap_req) && m_left == 0) begin
        m_front <= ~m_front;
        m_pend  <= 1'b0;
      end else begin
        m_pend <= m_pend | swap_req;
      end
      if (m_left == 0) begin
        if (clear_req) begin
          m_left <= 32;
          m_clr  <= 0;
        end
        if (write)
          for (int i = 0; i < 4; i++)
            if (be[i]) m_mem[m_front ^ 1'b1][wa][8*i +: 8] <= d[8*i +: 8];
      end else begin
        m_mem[m_front ^ 1'b1][m_clr] <= 32'd0;
        m_clr  <= m_clr + 1;
        m_left <= m_left - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_q", q, m_q);
      chk("model_front_bank", 32'(front_bank), 32'(m_front));
      chk("model_swap_pending", 32'(swap_pending), 32'(m_pend));
      chk("model_busy", 32'(busy), 32'(m_left != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    write       = 1'b0;
    swap_req    = 1'b0;
    frame_start = 1'b0;
    clear_req   = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] data, input logic [3:0] b);
    wa    = a;
    d     = data;
    be    = b;
    write = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; wa = 5'd0; ra = 5'd0; d = 32'd0; be = 4'd0;
    write = 1'b0; swap_req = 1'b0; frame_start = 1'b0; clear_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    // Preload both banks with zero so reads of unwritten entries are defined.
    for (int a = 0; a < 32; a++) wr(5'(a), 32'd0, 4'hF);
    swap_req = 1'b1; frame_start = 1'b1; tick();
    for (int a = 0; a < 32; a++) wr(5'(a), 32'd0, 4'hF);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_q", q, 32'd0);
    chk("reset_front", 32'(front_bank), 32'd0);
    chk("reset_pending", 32'(swap_pending), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Write then deferred swap.
    wr(5'd5, 32'hDEADBEEF, 4'hF);
    ra = 5'd5; tick();
    chk("pre_swap_q", q, 32'd0);
    swap_req = 1'b1; tick();
    chk("pending_set", 32'(swap_pending), 32'd1);
    repeat (9) tick();
    chk("pending_hold", 32'(swap_pending), 32'd1);
    frame_start = 1'b1; tick();
    chk("swap_front", 32'(front_bank), 32'd1);
    chk("swap_pending_clr", 32'(swap_pending), 32'd0);
    tick();
    chk("post_swap_q", q, 32'hDEADBEEF);

    // Byte enables, then simultaneous swap_req/frame_start.
    wr(5'd3, 32'h11223344, 4'hF);
    wr(5'd3, 32'hAABBCCDD, 4'b0101);
    swap_req = 1'b1; frame_start = 1'b1; tick();
    chk("simul_front", 32'(front_bank), 32'd0);
    chk("simul_pending", 32'(swap_pending), 32'd0);
    ra = 5'd3; tick();
    chk("byte_en_q", q, 32'h11BB33DD);

    // Clear engine: busy length and dropped write.
    for (int a = 0; a < 32; a++) wr(5'(a), 32'hFFFFFFFF, 4'hF);
    clear_req = 1'b1; tick();
    chk("clear_busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      if (n == 19) begin
        wa = 5'd7; d = 32'h12345678; be = 4'hF; write = 1'b1;
      end
      tick();
      n++;
    end
    chk("clear_busy_cycles", 32'(n + 1), 32'd33);
    swap_req = 1'b1; frame_start = 1'b1; tick();
    chk("clear_swap_front", 32'(front_bank), 32'd1);
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a); tick();
      chk("cleared_entry", q, 32'd0);
    end

    // Swap blocked by a running clear.
    swap_req = 1'b1; tick();
    clear_req = 1'b1; tick();
    frame_start = 1'b1; tick();
    chk("blocked_front", 32'(front_bank), 32'd1);
    chk("blocked_pending", 32'(swap_pending), 32'd1);
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    chk("blocked_busy_fell", 32'(busy), 32'd0);
    frame_start = 1'b1; tick();
    chk("unblocked_front", 32'(front_bank), 32'd0);
    chk("unblocked_pending", 32'(swap_pending), 32'd0);

    // Reset ten cycles into a clear with a swap pending.
    for (int a = 0; a < 32; a++) wr(5'(a), 32'hFFFFFFFF, 4'hF);
    swap_req = 1'b1; tick();
    clear_req = 1'b1; tick();
    chk("abort_pending_pre", 32'(swap_pending), 32'd1);
    repeat (9) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pending", 32'(swap_pending), 32'd0);
    chk("abort_front", 32'(front_bank), 32'd0);
    chk("abort_q", q, 32'd0);
    swap_req = 1'b1; frame_start = 1'b1; tick();
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a); tick();
      chk("partial_clear", q, (a < 9) ? 32'd0 : 32'hFFFFFFFF);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
